// File: rtl/sseg_pkg.sv
// Shared types, constants and the hex-to-segment table for the Basys3
// four-digit seven-segment scan driver.
package sseg_pkg;

    typedef logic [1:0] digit_idx_t;

    // One copy of everything software loads in a single write.
    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic        lzb;
    } disp_regs_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low cathode patterns, bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] SSEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [3:0] anOneHotLow(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational nibble to seven-segment (active-low) decoder built on the
// package lookup table.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segs
);

    assign o_segs = SSEG_TABLE[i_nibble];

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed scan driver for the Basys3 4-digit display with
// frame-synchronous update, anti-ghost blanking and leading-zero blanking.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int REFRESH_CNT = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WR,
    input  logic [15:0] DATA_IN,
    input  logic [3:0]  DP_IN,
    input  logic        LZB_EN,
    output logic [7:0]  SEGS,
    output logic [3:0]  AN,
    output logic        FRAME
);

    localparam int CNT_W = $clog2(REFRESH_CNT);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_CNT - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] r_slotCnt;
    digit_idx_t       r_digitIdx;
    disp_regs_t       r_shadow;
    disp_regs_t       r_active;
    logic [7:0]       r_segs;
    logic [3:0]       r_an;
    logic             r_frame;

    logic             w_slotWrap;
    logic             w_boundary;
    logic [CNT_W-1:0] w_slotNext;
    digit_idx_t       w_digitNext;
    disp_regs_t       w_writeVal;
    disp_regs_t       w_shadowNext;
    disp_regs_t       w_activeNext;
    logic [3:0]       w_nibble;
    logic [6:0]       w_segBits;
    logic             w_leadZero;
    logic             w_blank;

    assign w_slotWrap  = (r_slotCnt == SLOT_LAST);
    assign w_boundary  = w_slotWrap && (r_digitIdx == 2'd3);
    assign w_slotNext  = w_slotWrap ? '0 : r_slotCnt + 1'b1;
    assign w_digitNext = w_slotWrap ? r_digitIdx + 2'd1 : r_digitIdx;

    // A write landing on the boundary edge must reach the active copy
    // immediately, so active takes the post-write shadow value.
    assign w_writeVal   = {DATA_IN, DP_IN, LZB_EN};
    assign w_shadowNext = WR ? w_writeVal : r_shadow;
    assign w_activeNext = w_boundary ? w_shadowNext : r_active;

    assign w_nibble = w_activeNext.data[4*w_digitNext +: 4];

    hex_to_sseg u_decode (
        .i_nibble (w_nibble),
        .o_segs   (w_segBits)
    );

    // A digit is a leading zero when it and every digit to its left are 0.
    always_comb begin
        w_leadZero = 1'b0;
        case (w_digitNext)
            2'd3:    w_leadZero = (w_activeNext.data[15:12] == 4'h0);
            2'd2:    w_leadZero = (w_activeNext.data[15:8] == 8'h00);
            2'd1:    w_leadZero = (w_activeNext.data[15:4] == 12'h000);
            default: w_leadZero = 1'b0;
        endcase
        w_blank = (w_slotNext < BLANK_END) || (w_activeNext.lzb && w_leadZero);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_slotCnt  <= '0;
            r_digitIdx <= '0;
            r_shadow   <= '0;
            r_active   <= '0;
            r_segs     <= SEG_BLANK;
            r_an       <= AN_OFF;
            r_frame    <= 1'b0;
        end else begin
            r_slotCnt  <= w_slotNext;
            r_digitIdx <= w_digitNext;
            r_shadow   <= w_shadowNext;
            r_active   <= w_activeNext;
            r_frame    <= w_boundary;
            if (w_blank) begin
                r_segs <= SEG_BLANK;
                r_an   <= AN_OFF;
            end else begin
                r_segs <= {~w_activeNext.dp[w_digitNext], w_segBits};
                r_an   <= anOneHotLow(w_digitNext);
            end
        end
    end

    assign SEGS  = r_segs;
    assign AN    = r_an;
    assign FRAME = r_frame;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench for sseg_scan_driver: stimulus pushes predicted outputs
// from a frame-position reference model, a monitor pops and compares.
module tb_sseg_scan_driver;

    localparam int R  = 8;
    localparam int B  = 2;
    localparam int FR = 4 * R;

    typedef struct packed {
        logic [7:0] segs;
        logic [3:0] an;
        logic       frame;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        WR = 1'b0;
    logic [15:0] DATA_IN = '0;
    logic [3:0]  DP_IN = '0;
    logic        LZB_EN = 1'b0;
    logic [7:0]  SEGS;
    logic [3:0]  AN;
    logic        FRAME;

    int checks = 0;
    int errors = 0;
    exp_t expQ[$];

    // Reference model: position inside the 4*R frame plus software-visible registers.
    int          mPos = 0;
    logic [15:0] mShData = '0, mActData = '0;
    logic [3:0]  mShDp = '0, mActDp = '0;
    logic        mShLzb = 1'b0, mActLzb = 1'b0;
    logic [7:0]  refTable [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    sseg_scan_driver #(.REFRESH_CNT(R), .BLANK_CYC(B)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .WR      (WR),
        .DATA_IN (DATA_IN),
        .DP_IN   (DP_IN),
        .LZB_EN  (LZB_EN),
        .SEGS    (SEGS),
        .AN      (AN),
        .FRAME   (FRAME)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t predict(input logic frm);
        exp_t e;
        int digit;
        int slot;
        logic [15:0] upper;
        logic [3:0] nib;
        logic [7:0] pat;
        digit   = mPos / R;
        slot    = mPos % R;
        upper   = mActData >> (4 * digit);
        nib     = upper[3:0];
        e.frame = frm;
        e.segs  = 8'hFF;
        e.an    = 4'hF;
        if (slot >= B && !(mActLzb && digit > 0 && upper == 16'h0)) begin
            pat    = refTable[nib];
            e.an   = ~(4'b0001 << digit);
            e.segs = {~mActDp[digit], pat[6:0]};
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic rst, input logic wr, input logic [15:0] d,
                                 input logic [3:0] dp, input logic lzb);
        exp_t e;
        logic boundary;
        @(negedge CLK);
        RST = rst; WR = wr; DATA_IN = d; DP_IN = dp; LZB_EN = lzb;
        if (rst) begin
            mPos = 0;
            mShData = '0; mShDp = '0; mShLzb = 1'b0;
            mActData = '0; mActDp = '0; mActLzb = 1'b0;
            e = '{segs: 8'hFF, an: 4'hF, frame: 1'b0};
        end else begin
            boundary = (mPos == FR - 1);
            if (wr) begin
                mShData = d; mShDp = dp; mShLzb = lzb;
            end
            if (boundary) begin
                mActData = mShData; mActDp = mShDp; mActLzb = mShLzb;
            end
            mPos = (mPos + 1) % FR;
            e = predict(boundary);
        end
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    task automatic runUntilPos(input int p);
        for (int i = 0; i < FR && mPos != p; i++) applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req, input int cyc);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Monitor: compare each registered output set against the queued prediction.
    initial begin
        exp_t e;
        int cyc = 0;
        int lastFrame = -1;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("segs", SEGS, e.segs, cyc);
                checkOutput("an", {4'h0, AN}, {4'h0, e.an}, cyc);
                checkOutput("frame", {7'h0, FRAME}, {7'h0, e.frame}, cyc);
                checkOutput("an_onehot", 8'($countones(~AN) <= 1), 8'd1, cyc);
                if (RST) begin
                    lastFrame = -1;
                end else if (FRAME === 1'b1) begin
                    if (lastFrame >= 0) checkOutput("frame_period", 8'(cyc - lastFrame), 8'(FR), cyc);
                    lastFrame = cyc;
                end
            end
        end
    end

    initial begin
        logic [15:0] rd;
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        idle(FR + 8);

        runUntilPos(12);
        applyStimulus(1'b0, 1'b1, 16'h1A2F, 4'b0100, 1'b0);
        idle(2 * FR);

        runUntilPos(5);
        applyStimulus(1'b0, 1'b1, 16'h1111, 4'h0, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 16'h2222, 4'h0, 1'b0);
        runUntilPos(FR - 1);
        applyStimulus(1'b0, 1'b1, 16'h3333, 4'h0, 1'b0);
        idle(FR + 4);

        applyStimulus(1'b0, 1'b1, 16'h0005, 4'b1000, 1'b1);
        idle(2 * FR);
        applyStimulus(1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1);
        idle(2 * FR);

        runUntilPos(2 * R + 5);
        applyStimulus(1'b1, 1'b0, 16'hFFFF, 4'hF, 1'b1);
        idle(FR + 8);

        for (int i = 0; i < 200 * FR; i++) begin
            rd = 16'($urandom) >> (4 * $urandom_range(0, 4));
            applyStimulus(1'b0, ($urandom_range(0, 15) == 0), rd,
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        idle(2);

        @(negedge CLK);
        checkOutput("queue_drained", 8'(expQ.size()), 8'd0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
